// File: rtl/vga_pkg.sv
// Shared constants for the text-mode VGA engine: cell field positions,
// default 640x480@60 timing and the per-axis total derivation.
package vga_pkg;

  localparam int R_HI    = 15;
  localparam int G_HI    = 12;
  localparam int B_HI    = 9;
  localparam int CHAR_HI = 6;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_font_rom.sv
// Procedural glyph generator: bit ((col ^ line) mod 8) of the char code lights
// the pixel, bit 7 reading as blank, so any code yields a distinct pattern.
module vga_font_rom #(
  parameter int CHAR_W = 16,
  parameter int CHAR_H = 36
) (
  input  logic [6:0]                  ch,
  input  logic [$clog2(CHAR_W)-1:0]   col,
  input  logic [$clog2(CHAR_H)-1:0]   line,
  output logic                        mask
);

  logic [2:0] idx;
  logic [7:0] bits;

  assign idx  = 3'(col) ^ 3'(line);
  assign bits = {1'b0, ch};
  assign mask = bits[idx];

endmodule

// File: rtl/vga_text_engine.sv
// Parametrised text-mode VGA engine with scrolling and a 3-stage fetch pipeline.
// Optional blinking cursor is built when VGA_TEXT_CURSOR_EN is defined.
module vga_text_engine
  import vga_pkg::*;
#(
  parameter int H_ACTIVE     = DEF_H_ACTIVE,
  parameter int H_FP         = DEF_H_FP,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BP         = DEF_H_BP,
  parameter int V_ACTIVE     = DEF_V_ACTIVE,
  parameter int V_FP         = DEF_V_FP,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BP         = DEF_V_BP,
  parameter int COLS         = 40,
  parameter int ROWS         = 13,
  parameter int CHAR_W       = 16,
  parameter int CHAR_H       = 36,
  parameter int V_OFFSET     = 6,
  parameter int ADDR_W       = 9,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic [ADDR_W-1:0]         mem_addr,
  input  logic [15:0]               mem_data,
  input  logic                      scroll_we,
  input  logic [$clog2(ROWS)-1:0]   scroll_row,
  input  logic                      cursor_we,
  input  logic [ADDR_W-1:0]         cursor_addr,
  output logic                      hs,
  output logic                      vs,
  output logic [2:0]                r,
  output logic [2:0]                g,
  output logic [2:0]                b,
  output logic                      frame_start
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int CELLS   = COLS * ROWS;
  localparam int XW      = $clog2(H_TOTAL + 1);
  localparam int YW      = $clog2(V_TOTAL + 1);
  localparam int CW      = $clog2(CHAR_W);
  localparam int LW      = $clog2(CHAR_H);
  localparam int SW      = $clog2(ROWS);
  localparam int RW      = $clog2(ROWS) + 1;
  localparam int PW      = RW + 1;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y, y_next;
  logic [RW-1:0]     lrow;
  logic [LW-1:0]     lline;
  logic [SW-1:0]     base, pending;
  logic [PW-1:0]     psum, prow;
  logic [ADDR_W-1:0] rd_addr;
  logic              x_end, text_p0, hs_p0, vs_p0, wr_ok;
  logic [15:0]       mem [2**ADDR_W];
  logic [15:0]       rdata_p1;
  logic [CW-1:0]     col_p1;
  logic [LW-1:0]     line_p1;
  logic              vis_p1, hs_p1, vs_p1, fs_p1, mask;
  logic [8:0]        pix;

  assign x_end  = (x == XW'(H_TOTAL - 1));
  assign y_next = (y == YW'(V_TOTAL - 1)) ? '0 : y + 1'b1;

  // S0: raster counters plus a row/line tracker that avoids dividing y by CHAR_H
  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      lrow  <= '0;
      lline <= '0;
    end else if (x_end) begin
      x <= '0;
      y <= y_next;
      if (y_next == YW'(V_OFFSET)) begin
        lrow  <= '0;
        lline <= '0;
      end else if (lline == LW'(CHAR_H - 1)) begin
        lrow  <= lrow + 1'b1;
        lline <= '0;
      end else begin
        lline <= lline + 1'b1;
      end
    end else begin
      x <= x + 1'b1;
    end
  end

  assign text_p0 = (32'(x) < COLS * CHAR_W) && (32'(x) < H_ACTIVE) &&
                   (32'(y) >= V_OFFSET) && (32'(y) < V_OFFSET + ROWS * CHAR_H) &&
                   (32'(y) < V_ACTIVE);
  assign hs_p0   = !((32'(x) >= H_ACTIVE + H_FP) && (32'(x) < H_ACTIVE + H_FP + H_SYNC));
  assign vs_p0   = !((32'(y) >= V_ACTIVE + V_FP) && (32'(y) < V_ACTIVE + V_FP + V_SYNC));
  assign psum    = {1'b0, lrow} + PW'(base);
  assign prow    = (32'(psum) >= ROWS) ? psum - PW'(ROWS) : psum;
  assign rd_addr = ADDR_W'(32'(prow) * COLS + 32'(x >> CW));
  assign wr_ok   = we && (32'(mem_addr) < CELLS);

  // S1: synchronous read with write-through bypass; coordinates travel alongside
  always_ff @(posedge clk) begin
    if (wr_ok) mem[mem_addr] <= mem_data;
    rdata_p1 <= (wr_ok && (mem_addr == rd_addr)) ? mem_data : mem[rd_addr];
    col_p1   <= x[CW-1:0];
    line_p1  <= lline;
  end

  // S2: glyph lookup on S1-registered cell, colour/sync registered to the pins
  vga_font_rom #(.CHAR_W(CHAR_W), .CHAR_H(CHAR_H)) u_font (
    .ch   (rdata_p1[CHAR_HI:0]),
    .col  (col_p1),
    .line (line_p1),
    .mask (mask)
  );

`ifdef VGA_TEXT_CURSOR_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [ADDR_W-1:0] cursor;
  logic [BW-1:0]     blink;
  logic              phase, cur_hit_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cursor     <= '0;
      blink      <= '0;
      phase      <= 1'b0;
      cur_hit_p1 <= 1'b0;
    end else begin
      cur_hit_p1 <= phase && text_p0 && (rd_addr == cursor) && (lline >= LW'(CHAR_H - 3));
      if (cursor_we) begin
        cursor <= cursor_addr;
        phase  <= 1'b1;
        blink  <= '0;
      end else if (frame_start) begin
        if (blink == BW'(BLINK_FRAMES - 1)) begin
          blink <= '0;
          phase <= ~phase;
        end else begin
          blink <= blink + 1'b1;
        end
      end
    end
  end
`else
  logic unused_cursor;
  assign unused_cursor = ^{cursor_we, cursor_addr};
`endif

  always_comb begin
    pix = '0;
    if (vis_p1 && mask) pix = {rdata_p1[R_HI -: 3], rdata_p1[G_HI -: 3], rdata_p1[B_HI -: 3]};
`ifdef VGA_TEXT_CURSOR_EN
    if (vis_p1 && cur_hit_p1) pix = '1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vis_p1      <= 1'b0;
      hs_p1       <= 1'b1;
      vs_p1       <= 1'b1;
      fs_p1       <= 1'b0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      {r, g, b}   <= '0;
      frame_start <= 1'b0;
      base        <= '0;
      pending     <= '0;
    end else begin
      vis_p1      <= text_p0;
      hs_p1       <= hs_p0;
      vs_p1       <= vs_p0;
      fs_p1       <= (x == '0) && (y == '0);
      hs          <= hs_p1;
      vs          <= vs_p1;
      {r, g, b}   <= pix;
      frame_start <= fs_p1;
      if (scroll_we && (32'(scroll_row) < ROWS)) pending <= scroll_row;
      // base only moves at frame start so a frame never shows two scroll offsets
      if (frame_start) base <= pending;
    end
  end

endmodule

// File: tb/tb_vga_text_engine.sv
// Directed bench for vga_text_engine on a reduced raster (56x28 clocks per frame).
module tb_vga_text_engine;

  localparam int HT = 56;
  localparam int VT = 28;
  localparam int FR = HT * VT;
`ifdef VGA_TEXT_CURSOR_EN
  localparam logic [8:0] BAR = 9'h1FF;
`else
  localparam logic [8:0] BAR = 9'h000;
`endif

  typedef struct {
    int         x;
    int         y;
    logic       hs_e;
    logic       vs_e;
    logic       fs_e;
    logic [8:0] rgb_e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, we, scroll_we, cursor_we;
  logic [3:0] mem_addr, cursor_addr;
  logic [15:0] mem_data;
  logic [1:0] scroll_row;
  logic       hs, vs, frame_start;
  logic [2:0] r, g, b;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  vga_text_engine #(
    .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(22), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .COLS(5), .ROWS(3), .CHAR_W(8), .CHAR_H(6), .V_OFFSET(2),
    .ADDR_W(4), .BLINK_FRAMES(3)
  ) dut (
    .clk(clk), .rst(rst), .we(we), .mem_addr(mem_addr), .mem_data(mem_data),
    .scroll_we(scroll_we), .scroll_row(scroll_row),
    .cursor_we(cursor_we), .cursor_addr(cursor_addr),
    .hs(hs), .vs(vs), .r(r), .g(g), .b(b), .frame_start(frame_start)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic adv(input int target);
    while (ncyc < target) tick();
    checks++;
    if (ncyc != target) begin
      errors++;
      $display("FAIL sequencing: at cycle %0d expected %0d", ncyc, target);
    end
  endtask

  // displayed pixel (x,y) of frame f is on the outputs two clocks after its fetch
  task automatic at(input int f, input int x, input int y);
    adv(f * FR + y * HT + x + 2);
  endtask

  task automatic px(input string name, input int f, input int x, input int y, input logic [8:0] e);
    at(f, x, y);
    check(name, {r, g, b}, e);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    mem_addr = a;
    mem_data = d;
    we = 1'b1;
    tick();
    we = 1'b0;
  endtask

  task automatic addv(input int x, input int y, input logic h, input logic v, input logic f,
                      input logic [8:0] c);
    vec_t t;
    t.x = x; t.y = y; t.hs_e = h; t.vs_e = v; t.fs_e = f; t.rgb_e = c;
    tbl.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // frame-1 probes in raster order: x, y, hs, vs, frame_start, rgb
    addv( 0,  0, 1, 1, 1, 9'h000);
    addv( 1,  0, 1, 1, 0, 9'h000);
    addv(43,  0, 1, 1, 0, 9'h000);
    addv(44,  0, 0, 1, 0, 9'h000);
    addv(49,  0, 0, 1, 0, 9'h000);
    addv(50,  0, 1, 1, 0, 9'h000);
    addv( 0,  1, 1, 1, 0, 9'h000);
    addv( 0,  2, 1, 1, 0, 9'h1C0);
    addv( 1,  2, 1, 1, 0, 9'h000);
    addv( 6,  2, 1, 1, 0, 9'h1C0);
    addv( 7,  2, 1, 1, 0, 9'h000);
    addv( 8,  2, 1, 1, 0, 9'h038);
    addv(15,  2, 1, 1, 0, 9'h000);
    addv( 5,  3, 1, 1, 0, 9'h000);
    addv( 7,  3, 1, 1, 0, 9'h1C0);
    addv( 3,  5, 1, 1, 0, 9'h1C0);
    addv( 9,  7, 1, 1, 0, 9'h038);
    addv( 0,  8, 1, 1, 0, 9'h007);
    addv( 2,  8, 1, 1, 0, 9'h000);
    addv( 1,  9, 1, 1, 0, 9'h007);
    addv(32, 14, 1, 1, 0, 9'h1FF);
    addv(39, 19, 1, 1, 0, 9'h1FF);
    addv(40, 19, 1, 1, 0, 9'h000);
    addv(39, 20, 1, 1, 0, 9'h000);
    addv( 0, 23, 1, 1, 0, 9'h000);
    addv( 0, 24, 1, 0, 0, 9'h000);
    addv(45, 24, 0, 0, 0, 9'h000);
    addv( 0, 25, 1, 0, 0, 9'h000);
    addv( 0, 26, 1, 1, 0, 9'h000);

    rst = 1'b1; we = 1'b0; scroll_we = 1'b0; cursor_we = 1'b0;
    mem_addr = '0; mem_data = '0; scroll_row = '0; cursor_addr = '0;
    repeat (3) tick();
    check("reset_hs", {8'b0, hs}, 9'd1);
    check("reset_vs", {8'b0, vs}, 9'd1);
    check("reset_rgb", {r, g, b}, 9'h000);
    check("reset_fs", {8'b0, frame_start}, 9'd0);
    rst = 1'b0;
    ncyc = 0;

    for (int i = 0; i < 15; i++) wr(4'(i), 16'h0000);
    wr(4'd0, 16'hE041);
    wr(4'd1, 16'h1C7F);
    wr(4'd5, 16'h0381);
    wr(4'd14, 16'hFFFF);

    for (int i = 0; i < tbl.size(); i++) begin
      at(1, tbl[i].x, tbl[i].y);
      check($sformatf("v%0d_rgb", i), {r, g, b}, tbl[i].rgb_e);
      check($sformatf("v%0d_hs", i), {8'b0, hs}, {8'b0, tbl[i].hs_e});
      check($sformatf("v%0d_vs", i), {8'b0, vs}, {8'b0, tbl[i].vs_e});
      check($sformatf("v%0d_fs", i), {8'b0, frame_start}, {8'b0, tbl[i].fs_e});
    end

    // write lands on the very cycle its cell is fetched
    adv(2 * FR + 2 * HT + 8);
    wr(4'd1, 16'hE041);
    px("bypass", 2, 8, 2, 9'h1C0);
    px("blink_from_reset", 2, 0, 7, BAR);

    at(2, 0, 10);
    scroll_row = 2'd1;
    scroll_we = 1'b1;
    tick();
    scroll_we = 1'b0;
    wr(4'd15, 16'h0000);
    px("no_tear_oob_write", 2, 32, 14, 9'h1FF);

    px("scroll_row0", 3, 0, 2, 9'h007);
    px("scroll_row1", 3, 0, 8, 9'h000);
    px("scroll_row2", 3, 0, 14, 9'h1C0);
    px("scroll_row2_c4", 3, 32, 14, 9'h000);
    at(3, 0, 20);
    scroll_row = 2'd3;
    scroll_we = 1'b1;
    tick();
    scroll_we = 1'b0;
    px("scroll_oob_ignored", 4, 0, 2, 9'h007);

    at(5, 0, 1);
    cursor_addr = 4'd5;
    cursor_we = 1'b1;
    tick();
    cursor_we = 1'b0;
    px("cur_line2", 5, 0, 4, 9'h000);
    px("cur_line3", 5, 7, 5, BAR);
    px("cur_f5", 5, 0, 7, BAR);
    px("cur_other_cell", 5, 8, 7, 9'h000);
    px("cur_f7", 7, 0, 7, BAR);
    px("cur_f8", 8, 0, 7, 9'h000);
    px("cur_f10", 10, 0, 7, 9'h000);
    px("cur_f11", 11, 0, 7, BAR);

    at(12, 0, 24);
    check("vs_before_rst", {8'b0, vs}, 9'd0);
    rst = 1'b1;
    tick();
    check("midrst_hs", {8'b0, hs}, 9'd1);
    check("midrst_vs", {8'b0, vs}, 9'd1);
    check("midrst_rgb", {r, g, b}, 9'h000);
    check("midrst_fs", {8'b0, frame_start}, 9'd0);
    rst = 1'b0;
    ncyc = 0;
    at(0, 0, 0);
    check("restart_fs", {8'b0, frame_start}, 9'd1);
    at(0, 44, 0);
    check("restart_hs", {8'b0, hs}, 9'd0);
    px("mem_kept_base0", 0, 0, 2, 9'h1C0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
